dffntest_checker: RTL and testbench

- Self-checking stimulus/response harness for the 10-stage pipelined add chain in the dffntest app (operands a, b in; sum out).
- Drives the chain's a/b operands from an on-chip LFSR, holds each operand pair stable until the chain output has settled, then samples sum and compares it against a locally computed expected value.
- Reports pass/fail, mismatch count and the first failing vector.
- Sits beside the chain in the same clk domain and gives on-fabric pass/fail without a host.

---
 rtl/dffntest_checker.sv | 133 +++++++++++++
 tb/tb_dffntest_checker.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dffntest_checker.sv
// dffntest_checker: self-checking harness for the 10-stage pipelined add chain.
// A Galois LFSR supplies operand pairs. Each pair is held on a/b long enough for
// the chain to settle. The chain's sum is then compared against 6a+5b mod 2^32,
// and the checker reports pass/fail, a mismatch count and the first failing vector.
module dffntest_checker #(
  parameter int unsigned NUM_VECTORS = 16,
  parameter int unsigned WAIT_CYCLES = 12,
  parameter logic [31:0] SEED_A      = 32'h0000_0001,
  parameter logic [31:0] SEED_B      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] sum,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] vec_count,
  output logic [15:0] err_count,
  output logic [15:0] first_fail_idx,
  output logic [31:0] first_fail_sum
);

  localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;
  // An all-zero Galois LFSR never leaves zero, so a zero seed is replaced by 1.
  localparam logic [31:0] SEED_LOAD  = (SEED_A == 32'd0) ? 32'd1 : SEED_A;
  localparam logic [15:0] NUM_VEC_16 = 16'(NUM_VECTORS);
  localparam logic [15:0] WAIT_LOAD  = 16'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t      state;
  logic [31:0] lfsr;
  logic [31:0] expected;
  logic [15:0] wait_cnt;
  logic        mismatch;
  logic        last_vector;

  // One right-shift step of the Galois LFSR.
  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

  // Compare outcome for the pair currently under test.
  assign mismatch    = (sum != expected);
  assign last_vector = ((vec_count + 16'd1) == NUM_VEC_16);

  // Run sequencer: load a pair, hold it, check sum, repeat until NUM_VECTORS are done.
  // NOTE: every register here is written with <=, so all of them update together
  // from the same pre-edge values; a blocking = would let later statements see
  // half-updated state and break that.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      lfsr           <= SEED_LOAD;
      a              <= '0;
      b              <= '0;
      expected       <= '0;
      wait_cnt       <= '0;
      vec_count      <= '0;
      err_count      <= '0;
      first_fail_idx <= '0;
      first_fail_sum <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            vec_count      <= '0;
            err_count      <= '0;
            first_fail_idx <= '0;
            first_fail_sum <= '0;
            done           <= 1'b0;
            pass           <= 1'b0;
            busy           <= 1'b1;
            lfsr           <= SEED_LOAD;
            state          <= S_LOAD;
          end
        end
        S_LOAD: begin
          a        <= lfsr;
          b        <= {lfsr[15:0], lfsr[31:16]} ^ SEED_B;
          lfsr     <= lfsr_next(lfsr);
          wait_cnt <= WAIT_LOAD;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          expected <= (a << 2) + (a << 1) + (b << 2) + b;
          // The counter is loaded with WAIT_CYCLES-1 and WAIT exits on zero,
          // so WAIT lasts WAIT_CYCLES clocks. The compare then lands
          // WAIT_CYCLES+1 clocks after a/b change.
          if (wait_cnt == 16'd0) begin
            state <= S_CHECK;
          end else begin
            wait_cnt <= wait_cnt - 16'd1;
          end
        end
        S_CHECK: begin
          if (mismatch) begin
            if (err_count != 16'hFFFF) begin
              err_count <= err_count + 16'd1;
            end
            if (err_count == 16'd0) begin
              first_fail_idx <= vec_count;
              first_fail_sum <= sum;
            end
          end
          vec_count <= vec_count + 16'd1;
          if (last_vector) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == 16'd0) && !mismatch;
          end else begin
            state <= S_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dffntest_checker.sv
// Testbench for dffntest_checker. Several checker instances, each with different
// parameters, run beside a behavioural model of the add chain: 6a+5b with an
// 11-clock settle time. The expected vectors come from an arithmetic model of the
// LFSR and the operand rules.
module tb_dffntest_checker;

  localparam logic [31:0] TAPS = 32'h8020_0003;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_main = 1'b0;
  logic start_aux = 1'b0;
  always #5 clk = ~clk;

  // main instance: default parameters
  logic [31:0] a_main, b_main, sum_main, ffs_main;
  logic        busy_main, done_main, pass_main;
  logic [15:0] vec_main, err_main, ffi_main;
  // short instance: WAIT_CYCLES=9
  logic [31:0] a_short, b_short, sum_short, ffs_short;
  logic        busy_short, done_short, pass_short;
  logic [15:0] vec_short, err_short, ffi_short;
  // w11 instance: WAIT_CYCLES=11
  logic [31:0] a_w11, b_w11, sum_w11, ffs_w11;
  logic        busy_w11, done_w11, pass_w11;
  logic [15:0] vec_w11, err_w11, ffi_w11;
  // ovf instance: all-ones seeds
  logic [31:0] a_ovf, b_ovf, sum_ovf, ffs_ovf;
  logic        busy_ovf, done_ovf, pass_ovf;
  logic [15:0] vec_ovf, err_ovf, ffi_ovf;
  // zero instance: SEED_A=0 lockup guard
  logic [31:0] a_zero, b_zero, sum_zero, ffs_zero;
  logic        busy_zero, done_zero, pass_zero;
  logic [15:0] vec_zero, err_zero, ffi_zero;

  dffntest_checker u_main (
    .clk(clk), .rst_n(rst_n), .start(start_main), .sum(sum_main), .a(a_main), .b(b_main),
    .busy(busy_main), .done(done_main), .pass(pass_main), .vec_count(vec_main),
    .err_count(err_main), .first_fail_idx(ffi_main), .first_fail_sum(ffs_main));

  dffntest_checker #(.WAIT_CYCLES(9)) u_short (
    .clk(clk), .rst_n(rst_n), .start(start_aux), .sum(sum_short), .a(a_short), .b(b_short),
    .busy(busy_short), .done(done_short), .pass(pass_short), .vec_count(vec_short),
    .err_count(err_short), .first_fail_idx(ffi_short), .first_fail_sum(ffs_short));

  dffntest_checker #(.WAIT_CYCLES(11)) u_w11 (
    .clk(clk), .rst_n(rst_n), .start(start_aux), .sum(sum_w11), .a(a_w11), .b(b_w11),
    .busy(busy_w11), .done(done_w11), .pass(pass_w11), .vec_count(vec_w11),
    .err_count(err_w11), .first_fail_idx(ffi_w11), .first_fail_sum(ffs_w11));

  dffntest_checker #(.NUM_VECTORS(4), .SEED_A(32'hFFFF_FFFF), .SEED_B(32'hFFFF_FFFF)) u_ovf (
    .clk(clk), .rst_n(rst_n), .start(start_aux), .sum(sum_ovf), .a(a_ovf), .b(b_ovf),
    .busy(busy_ovf), .done(done_ovf), .pass(pass_ovf), .vec_count(vec_ovf),
    .err_count(err_ovf), .first_fail_idx(ffi_ovf), .first_fail_sum(ffs_ovf));

  dffntest_checker #(.NUM_VECTORS(2), .SEED_A(32'h0)) u_zero (
    .clk(clk), .rst_n(rst_n), .start(start_aux), .sum(sum_zero), .a(a_zero), .b(b_zero),
    .busy(busy_zero), .done(done_zero), .pass(pass_zero), .vec_count(vec_zero),
    .err_count(err_zero), .first_fail_idx(ffi_zero), .first_fail_sum(ffs_zero));

  // ---------------- chain model ----------------
  int          sum_mode = 0;   // 0 golden, 1 tied to zero, 2 golden with a fault on one vector
  logic [31:0] fault_a = '0;
  logic [31:0] fault_mask = '0;

  function automatic logic [31:0] chain_fn(input logic [31:0] x, input logic [31:0] y);
    return x * 32'd6 + y * 32'd5;
  endfunction

  logic [31:0] chain_a [5];
  logic [31:0] chain_b [5];
  logic [31:0] pipe [5][11];
  assign chain_a[0] = a_main;  assign chain_b[0] = b_main;
  assign chain_a[1] = a_short; assign chain_b[1] = b_short;
  assign chain_a[2] = a_w11;   assign chain_b[2] = b_w11;
  assign chain_a[3] = a_ovf;   assign chain_b[3] = b_ovf;
  assign chain_a[4] = a_zero;  assign chain_b[4] = b_zero;

  // 11-deep chain pipeline per instance; the main one can inject a fault on one vector.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 5; k++)
        for (int i = 0; i < 11; i++) pipe[k][i] <= '0;
    end else begin
      for (int k = 0; k < 5; k++) begin
        pipe[k][0] <= chain_fn(chain_a[k], chain_b[k]) ^
                      ((k == 0 && sum_mode == 2 && chain_a[k] == fault_a) ? fault_mask : 32'd0);
        for (int i = 1; i < 11; i++) pipe[k][i] <= pipe[k][i-1];
      end
    end
  end

  assign sum_main  = (sum_mode == 1) ? 32'd0 : pipe[0][10];
  assign sum_short = pipe[1][10];
  assign sum_w11   = pipe[2][10];
  assign sum_ovf   = pipe[3][10];
  assign sum_zero  = pipe[4][10];

  // ---------------- reference vectors ----------------
  logic [31:0] va[$], vb[$], vexp[$];

  task automatic build_model(input logic [31:0] sa, input logic [31:0] sb, input int n);
    logic [31:0] s;
    va.delete(); vb.delete(); vexp.delete();
    s = (sa == 0) ? 32'd1 : sa;
    for (int i = 0; i < n; i++) begin
      va.push_back(s);
      vb.push_back(((s % 32'h10000) * 32'h10000 + s / 32'h10000) ^ sb);
      vexp.push_back(va[i] * 32'd6 + vb[i] * 32'd5);
      s = (s % 2 == 1) ? ((s / 2) ^ TAPS) : (s / 2);
    end
  endtask

  // Sequence of operand-a values seen on the main instance.
  logic [31:0] seen[$];
  logic [31:0] last_a = '0;
  always @(negedge clk) begin
    if (a_main !== last_a) begin
      seen.push_back(a_main);
      last_a <= a_main;
    end
  end

  function automatic bit seq_ok();
    if (seen.size() != va.size()) return 1'b0;
    foreach (va[i]) if (seen[i] !== va[i]) return 1'b0;
    return 1'b1;
  endfunction

  int n_checks = 0;
  int n_pass = 0;

  function automatic logic get_done(input int which);
    case (which)
      0: return done_main;
      1: return done_short;
      2: return done_w11;
      3: return done_ovf;
      default: return done_zero;
    endcase
  endfunction

  task automatic wait_done(input int which, input int budget, input string name);
    int cyc = 0;
    while (get_done(which) !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (get_done(which) !== 1'b1) $display("FAIL %s_timeout: done=%b after %0d cycles, required 1", name, get_done(which), cyc);
    else n_pass++;
  endtask

  task automatic wait_a_main(input logic [31:0] val, input int budget, input string name);
    int cyc = 0;
    while (a_main !== val && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (a_main !== val) $display("FAIL %s_timeout: a=%h, required %h", name, a_main, val);
    else n_pass++;
  endtask

  task automatic pulse_main();
    @(negedge clk); start_main = 1'b1;
    @(negedge clk); start_main = 1'b0;
  endtask

  task automatic pulse_aux();
    @(negedge clk); start_aux = 1'b1;
    @(negedge clk); start_aux = 1'b0;
  endtask

  // Checks shared by each completed main run.
  task automatic check_main_result(input string name, input logic [15:0] e_err,
                                   input logic [15:0] e_ffi, input logic [31:0] e_ffs);
    n_checks++;
    if (err_main !== e_err) $display("FAIL %s_err: got %0d, required %0d", name, err_main, e_err);
    else n_pass++;
    n_checks++;
    if (pass_main !== (e_err == 0)) $display("FAIL %s_pass: got %b, required %b", name, pass_main, e_err == 0);
    else n_pass++;
    n_checks++;
    if (vec_main !== 16'd16) $display("FAIL %s_vec: got %0d, required 16", name, vec_main);
    else n_pass++;
    n_checks++;
    if ({ffi_main, ffs_main} !== {e_ffi, e_ffs})
      $display("FAIL %s_first_fail: got idx %0d sum %h, required idx %0d sum %h", name, ffi_main, ffs_main, e_ffi, e_ffs);
    else n_pass++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({a_main, b_main, vec_main, err_main, ffi_main, ffs_main, busy_main, done_main, pass_main} !== '0)
      $display("FAIL reset_outputs: a=%h b=%h vec=%0d err=%0d busy=%b done=%b pass=%b, required all 0",
               a_main, b_main, vec_main, err_main, busy_main, done_main, pass_main);
    else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy_main, done_main, a_main} !== '0)
      $display("FAIL reset_idle: busy=%b done=%b a=%h, required 0", busy_main, done_main, a_main);
    else n_pass++;
  endtask

  task automatic test_golden_run();
    sum_mode = 0;
    pulse_main();
    seen.delete();
    @(negedge clk);
    n_checks++;
    if ({a_main, b_main, busy_main} !== {32'h0000_0001, 32'h0001_0000, 1'b1})
      $display("FAIL golden_vec0: a=%h b=%h busy=%b, required 00000001 00010000 1", a_main, b_main, busy_main);
    else n_pass++;
    wait_done(0, 400, "golden");
    n_checks++;
    if (seq_ok() !== 1'b1) $display("FAIL golden_sequence: %0d vectors seen, required %0d in LFSR order", seen.size(), va.size());
    else n_pass++;
    check_main_result("golden", 16'd0, 16'd0, 32'd0);
  endtask

  task automatic test_stuck_zero();
    logic [15:0] e_err;
    logic [15:0] e_ffi;
    e_err = 0;
    e_ffi = 0;
    for (int i = va.size() - 1; i >= 0; i--)
      if (vexp[i] != 0) begin e_err++; e_ffi = 16'(i); end
    sum_mode = 1;
    pulse_main();
    wait_done(0, 400, "zero");
    check_main_result("zero", e_err, e_ffi, 32'd0);
    sum_mode = 0;
  endtask

  task automatic test_fault(input int idx, input logic [31:0] mask, input string name);
    sum_mode = 2;
    fault_a = va[idx];
    fault_mask = mask;
    repeat ($urandom_range(0, 4)) @(negedge clk);
    pulse_main();
    wait_done(0, 400, name);
    check_main_result(name, 16'd1, 16'(idx), vexp[idx] ^ mask);
    sum_mode = 0;
  endtask

  task automatic test_random_faults();
    for (int r = 0; r < 3; r++) test_fault($urandom_range(0, 15), $urandom | 32'd1, "rand_fault");
  endtask

  task automatic test_back_to_back();
    sum_mode = 0;
    pulse_main();
    wait_a_main(va[2], 200, "b2b_reach_vec2");
    pulse_main();
    n_checks++;
    if ({vec_main, a_main, busy_main, done_main} !== {16'd2, va[2], 1'b1, 1'b0})
      $display("FAIL b2b_busy_start: vec=%0d a=%h busy=%b done=%b, required 2 %h 1 0", vec_main, a_main, busy_main, done_main, va[2]);
    else n_pass++;
    wait_done(0, 400, "b2b_run1");
    check_main_result("b2b_run1", 16'd0, 16'd0, 32'd0);
    pulse_main();
    seen.delete();
    n_checks++;
    if ({busy_main, done_main, pass_main, vec_main, err_main} !== {1'b1, 1'b0, 1'b0, 16'd0, 16'd0})
      $display("FAIL b2b_restart: busy=%b done=%b pass=%b vec=%0d err=%0d, required 1 0 0 0 0",
               busy_main, done_main, pass_main, vec_main, err_main);
    else n_pass++;
    wait_done(0, 400, "b2b_run2");
    n_checks++;
    if (seq_ok() !== 1'b1) $display("FAIL b2b_sequence: %0d vectors seen, required %0d matching run 1", seen.size(), va.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    sum_mode = 0;
    pulse_main();
    wait_a_main(va[3], 300, "rst_reach_vec3");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a_main, b_main, vec_main, err_main, ffi_main, ffs_main, busy_main, done_main, pass_main} !== '0)
      $display("FAIL midrun_reset: a=%h vec=%0d busy=%b done=%b, required all 0", a_main, vec_main, busy_main, done_main);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    pulse_main();
    seen.delete();
    @(negedge clk);
    n_checks++;
    if ({a_main, vec_main} !== {32'h0000_0001, 16'd0})
      $display("FAIL midrun_restart: a=%h vec=%0d, required 00000001 0", a_main, vec_main);
    else n_pass++;
    wait_done(0, 400, "midrun_rerun");
    check_main_result("midrun_rerun", 16'd0, 16'd0, 32'd0);
  endtask

  task automatic test_short_wait();
    pulse_aux();
    wait_done(1, 400, "short");
    wait_done(2, 400, "w11");
    n_checks++;
    if (err_short == 16'd0 || pass_short !== 1'b0)
      $display("FAIL short_wait: err=%0d pass=%b, required err nonzero and pass 0", err_short, pass_short);
    else n_pass++;
    n_checks++;
    if ({pass_w11, err_w11, vec_w11} !== {1'b1, 16'd0, 16'd16})
      $display("FAIL wait11: pass=%b err=%0d vec=%0d, required 1 0 16", pass_w11, err_w11, vec_w11);
    else n_pass++;
  endtask

  task automatic test_overflow();
    wait_done(3, 200, "ovf_first");
    wait_done(4, 200, "zero_seed_first");
    pulse_aux();
    @(negedge clk);
    n_checks++;
    if ({a_ovf, b_ovf} !== {32'hFFFF_FFFF, 32'h0})
      $display("FAIL ovf_vec0: a=%h b=%h, required ffffffff 00000000", a_ovf, b_ovf);
    else n_pass++;
    n_checks++;
    if ({a_zero, b_zero} !== {32'h1, 32'h0001_0000})
      $display("FAIL zero_seed_vec0: a=%h b=%h, required 00000001 00010000", a_zero, b_zero);
    else n_pass++;
    wait_done(3, 200, "ovf");
    wait_done(4, 200, "zero_seed");
    n_checks++;
    if ({pass_ovf, err_ovf, vec_ovf} !== {1'b1, 16'd0, 16'd4})
      $display("FAIL ovf_result: pass=%b err=%0d vec=%0d, required 1 0 4", pass_ovf, err_ovf, vec_ovf);
    else n_pass++;
    n_checks++;
    if ({pass_zero, vec_zero} !== {1'b1, 16'd2})
      $display("FAIL zero_seed_result: pass=%b vec=%0d, required 1 2", pass_zero, vec_zero);
    else n_pass++;
  endtask

  initial begin
    build_model(32'h1, 32'h0, 16);
    test_reset();
    test_golden_run();
    test_stuck_zero();
    test_fault(5, 32'd1, "fault_vec5");
    test_random_faults();
    test_back_to_back();
    test_reset_mid_run();
    test_short_wait();
    test_overflow();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
